// File: rtl/noc_route_pkg.sv
// rtl/noc_route_pkg.sv - shared FSM state type, counter width and route function for noc_route_node
package noc_route_pkg;

    localparam int CNT_W      = 16;
    localparam int MAX_ADDR_W = 16;
    localparam int MAX_SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        DATA = 2'd2
    } state_e;

    // Leaf nodes keep matching traffic local (port 0) and send the rest up the
    // tree on the last port; tree nodes take the SEL_W address bits that sit
    // immediately below the masked prefix.
    function automatic logic [MAX_SEL_W-1:0] route_port(
        input logic [MAX_ADDR_W-1:0] addr,
        input logic [MAX_ADDR_W-1:0] mask,
        input logic [MAX_ADDR_W-1:0] node_addr,
        input logic                  leaf,
        input int                    addr_w,
        input int                    sel_w,
        input int                    num_out
    );
        logic [MAX_ADDR_W-1:0] shifted;
        logic [MAX_SEL_W-1:0]  port;
        int                    prefix_len;
        prefix_len = $countones(mask);
        shifted    = '0;
        if (leaf) begin
            if ((addr & mask) == node_addr) begin
                port = '0;
            end else begin
                port = MAX_SEL_W'(num_out - 1);
            end
        end else begin
            shifted = addr >> (addr_w - prefix_len - sel_w);
            port    = MAX_SEL_W'(shifted & MAX_ADDR_W'((1 << sel_w) - 1));
        end
        return port;
    endfunction

endpackage

// File: rtl/noc_route_fifo.sv
// rtl/noc_route_fifo.sv - input flit FIFO with power-of-two depth and wrapping pointers
module noc_route_fifo #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 2,
    parameter int PTR_W      = $clog2(FIFO_DEPTH),
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Storage array; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; push+pop keeps count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/noc_route_node.sv
// rtl/noc_route_node.sv - NoC route node: input FIFO, route latch, select-before-data handshake (optional NOC_ROUTE_CNT_EN per-port counters)
module noc_route_node
    import noc_route_pkg::*;
#(
    parameter int              DATA_W     = 9,
    parameter int              ADDR_LSB   = 5,
    parameter int              ADDR_W     = 4,
    parameter int              NUM_OUT    = 2,
    parameter int              SEL_W      = $clog2(NUM_OUT),
    parameter int              FIFO_DEPTH = 2,
    parameter int              LEAF       = 1,
    parameter logic [ADDR_W-1:0] NODE_ADDR = 4'b1000,
    parameter logic [ADDR_W-1:0] NODE_MASK = 4'b1110
) (
    input  logic                     CLK,
    input  logic                     _RESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     sel_valid,
    input  logic                     sel_ready,
    output logic [SEL_W-1:0]         sel_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
`ifdef NOC_ROUTE_CNT_EN
    output logic [NUM_OUT*CNT_W-1:0] route_cnt,
`endif
    output logic [DATA_W-1:0]        out_data
);

    localparam int PREFIX_LEN = $countones(NODE_MASK);
    localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);

    if (SEL_W != $clog2(NUM_OUT)) begin : g_bad_sel_w
        $error("SEL_W is derived from NUM_OUT and must not be overridden");
    end
    if (NUM_OUT < 2 || NUM_OUT > 8 || (NUM_OUT & (NUM_OUT - 1)) != 0) begin : g_bad_num_out
        $error("NUM_OUT must be a power of two between 2 and 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (ADDR_W > MAX_ADDR_W || ADDR_LSB + ADDR_W > DATA_W) begin : g_bad_addr
        $error("address field does not fit the flit or the route function");
    end
    if (LEAF == 0 && PREFIX_LEN + SEL_W > ADDR_W) begin : g_bad_tree
        $error("tree mode needs SEL_W address bits below the masked prefix");
    end

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [SEL_W-1:0]    port_q, port_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic [DATA_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FCNT_W-1:0]   fifo_count;
    logic                out_fire;

    assign in_ready  = !_RESET && (fifo_count < FCNT_W'(FIFO_DEPTH));
    assign fifo_push = in_valid && !fifo_full && !_RESET;
    assign out_fire  = (state_q == DATA) && out_ready[port_q];

    noc_route_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (_RESET),
        .push_i  (fifo_push),
        .wdata_i (in_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next state: load the FIFO head and its route whenever a slot frees up.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        port_d    = port_q;
        fifo_pop  = 1'b0;
        sel_valid = 1'b0;
        sel_data  = '0;
        out_valid = '0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_rdata;
                    port_d   = SEL_W'(route_port(MAX_ADDR_W'(fifo_rdata[ADDR_LSB +: ADDR_W]),
                                                 MAX_ADDR_W'(NODE_MASK), MAX_ADDR_W'(NODE_ADDR),
                                                 LEAF != 0, ADDR_W, SEL_W, NUM_OUT));
                    state_d  = SEL;
                end
            end
            SEL: begin
                sel_valid = 1'b1;
                sel_data  = port_q;
                if (sel_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                out_valid[port_q] = 1'b1;
                out_data          = hold_q;
                if (out_ready[port_q]) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        hold_d   = fifo_rdata;
                        port_d   = SEL_W'(route_port(MAX_ADDR_W'(fifo_rdata[ADDR_LSB +: ADDR_W]),
                                                     MAX_ADDR_W'(NODE_MASK), MAX_ADDR_W'(NODE_ADDR),
                                                     LEAF != 0, ADDR_W, SEL_W, NUM_OUT));
                        state_d  = SEL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, held flit and latched route; reset drops the flit in flight.
    always_ff @(posedge CLK) begin
        if (_RESET) begin
            state_q <= IDLE;
            hold_q  <= '0;
            port_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            port_q  <= port_d;
        end
    end

`ifdef NOC_ROUTE_CNT_EN
    for (genvar p = 0; p < NUM_OUT; p++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        // Saturating count of completed data transfers to this port.
        always_ff @(posedge CLK) begin
            if (_RESET) begin
                cnt_q <= '0;
            end else if (out_fire && port_q == SEL_W'(p) && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
        assign route_cnt[p*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_noc_route_node.sv
// tb/tb_noc_route_node.sv - scoreboard bench for noc_route_node (leaf instance and tree instance)
module tb_noc_route_node;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst;

    logic        a_in_valid, a_in_ready, a_sel_valid, a_sel_ready;
    logic [8:0]  a_in_data, a_out_data;
    logic [0:0]  a_sel_data;
    logic [1:0]  a_out_valid, a_out_ready;

    logic        b_in_valid, b_in_ready, b_sel_valid, b_sel_ready;
    logic [8:0]  b_in_data, b_out_data;
    logic [1:0]  b_sel_data;
    logic [3:0]  b_out_valid, b_out_ready;

`ifdef NOC_ROUTE_CNT_EN
    logic [31:0] a_route_cnt;
    logic [63:0] b_route_cnt;
`endif

    noc_route_node dut_a (
        .CLK       (CLK),
        ._RESET    (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .sel_valid (a_sel_valid),
        .sel_ready (a_sel_ready),
        .sel_data  (a_sel_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
`ifdef NOC_ROUTE_CNT_EN
        .route_cnt (a_route_cnt),
`endif
        .out_data  (a_out_data)
    );

    noc_route_node #(
        .NUM_OUT   (4),
        .LEAF      (0),
        .NODE_MASK (4'b1000)
    ) dut_b (
        .CLK       (CLK),
        ._RESET    (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .sel_valid (b_sel_valid),
        .sel_ready (b_sel_ready),
        .sel_data  (b_sel_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
`ifdef NOC_ROUTE_CNT_EN
        .route_cnt (b_route_cnt),
`endif
        .out_data  (b_out_data)
    );

    typedef struct {
        logic [2:0] sel;
        logic [8:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the leaf instance: select compared on its handshake, data popped on its handshake.
    logic a_sel_seen = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (rst) begin
            a_sel_seen = 1'b0;
        end else begin
            check("a_sel_out_exclusive", {31'b0, a_sel_valid && (a_out_valid != 2'b00)}, 32'd0);
            if (a_sel_valid && a_sel_ready) begin
                check("a_sel_expected", {31'b0, qa.size() != 0}, 32'd1);
                if (qa.size() != 0) check("a_sel_data", {31'b0, a_sel_data}, {29'b0, qa[0].sel});
                a_sel_seen = 1'b1;
            end
            if ((a_out_valid & a_out_ready) != 2'b00) begin
                check("a_data_expected", {31'b0, qa.size() != 0}, 32'd1);
                check("a_sel_before_data", {31'b0, a_sel_seen}, 32'd1);
                a_sel_seen = 1'b0;
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    check("a_out_valid", {30'b0, a_out_valid}, 32'(1) << e.sel);
                    check("a_out_data", {23'b0, a_out_data}, {23'b0, e.data});
                end
            end
        end
    end

    // Monitor for the tree instance.
    logic b_sel_seen = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (rst) begin
            b_sel_seen = 1'b0;
        end else begin
            check("b_sel_out_exclusive", {31'b0, b_sel_valid && (b_out_valid != 4'b0000)}, 32'd0);
            if (b_sel_valid && b_sel_ready) begin
                check("b_sel_expected", {31'b0, qb.size() != 0}, 32'd1);
                if (qb.size() != 0) check("b_sel_data", {30'b0, b_sel_data}, {29'b0, qb[0].sel});
                b_sel_seen = 1'b1;
            end
            if ((b_out_valid & b_out_ready) != 4'b0000) begin
                check("b_data_expected", {31'b0, qb.size() != 0}, 32'd1);
                check("b_sel_before_data", {31'b0, b_sel_seen}, 32'd1);
                b_sel_seen = 1'b0;
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    check("b_out_valid", {28'b0, b_out_valid}, 32'(1) << e.sel);
                    check("b_out_data", {23'b0, b_out_data}, {23'b0, e.data});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the input transfer.
    task automatic send_a(input logic [8:0] d, input logic [2:0] s);
        int n;
        exp_t e;
        n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        while (!a_in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("a_in_accept_timeout", {31'b0, n < 100}, 32'd1);
        @(posedge CLK);
        e.sel  = s;
        e.data = d;
        qa.push_back(e);
        @(negedge CLK);
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [8:0] d, input logic [2:0] s);
        int n;
        exp_t e;
        n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        while (!b_in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("b_in_accept_timeout", {31'b0, n < 100}, 32'd1);
        @(posedge CLK);
        e.sel  = s;
        e.data = d;
        qb.push_back(e);
        @(negedge CLK);
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (qa.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("a_drain", qa.size(), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic drain_b();
        int n;
        n = 0;
        while (qb.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("b_drain", qb.size(), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_sel_ready = 1'b1;
        a_out_ready = 2'b11;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_sel_ready = 1'b1;
        b_out_ready = 4'b1111;

        // Reset held for two cycles, then idle outputs.
        repeat (2) @(negedge CLK);
        check("rst_a_in_ready", {31'b0, a_in_ready}, 32'd0);
        check("rst_b_in_ready", {31'b0, b_in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge CLK);
        check("idle_a_in_ready", {31'b0, a_in_ready}, 32'd1);
        check("idle_b_in_ready", {31'b0, b_in_ready}, 32'd1);
        check("idle_a_sel_valid", {31'b0, a_sel_valid}, 32'd0);
        check("idle_a_out_valid", {30'b0, a_out_valid}, 32'd0);
        check("idle_a_sel_data", {31'b0, a_sel_data}, 32'd0);
        check("idle_a_out_data", {23'b0, a_out_data}, 32'd0);
        check("idle_b_sel_valid", {31'b0, b_sel_valid}, 32'd0);
        check("idle_b_out_valid", {28'b0, b_out_valid}, 32'd0);
`ifdef NOC_ROUTE_CNT_EN
        check("idle_a_route_cnt", a_route_cnt, 32'd0);
        check("idle_b_route_cnt_lo", b_route_cnt[31:0], 32'd0);
        check("idle_b_route_cnt_hi", b_route_cnt[63:32], 32'd0);
`endif

        // Leaf match A=1001 with latency: select in t+2, data in t+3.
        send_a(9'h130, 3'd0);
        check("lat_a_sel_t1", {31'b0, a_sel_valid}, 32'd0);
        @(negedge CLK);
        check("lat_a_sel_t2", {31'b0, a_sel_valid}, 32'd1);
        check("lat_a_sel_data", {31'b0, a_sel_data}, 32'd0);
        @(negedge CLK);
        check("lat_a_out_t3", {30'b0, a_out_valid}, 32'd1);
        check("lat_a_out_data", {23'b0, a_out_data}, 32'h130);
        drain_a();

        // Leaf miss A=0101 goes to the uplink port.
        send_a(9'h0A0, 3'd1);
        drain_a();

        // Tree mode, prefix length 1, two select bits A[2:1].
        send_b(9'h1A0, 3'd2);
        send_b(9'h060, 3'd1);
        send_b(9'h0C0, 3'd3);
        send_b(9'h100, 3'd0);
        drain_b();

        // Ready on the non-selected port must not complete the transfer.
        a_out_ready = 2'b10;
        send_a(9'h110, 3'd0);
        repeat (5) @(negedge CLK);
        check("ignore_a_out_valid", {30'b0, a_out_valid}, 32'd1);
        check("ignore_a_pending", qa.size(), 32'd1);
        a_out_ready = 2'b11;
        drain_a();

        // Backpressure: one flit held, two buffered, then full.
        a_sel_ready = 1'b0;
        send_a(9'h130, 3'd0);
        send_a(9'h0A0, 3'd1);
        check("bp_a_in_ready_mid", {31'b0, a_in_ready}, 32'd1);
        send_a(9'h1F0, 3'd1);
        check("bp_a_in_ready_full", {31'b0, a_in_ready}, 32'd0);
        repeat (3) @(negedge CLK);
        check("bp_a_in_ready_hold", {31'b0, a_in_ready}, 32'd0);
        check("bp_a_sel_valid", {31'b0, a_sel_valid}, 32'd1);
        check("bp_a_sel_head", {31'b0, a_sel_data}, 32'd0);
        a_sel_ready = 1'b1;
        drain_a();
        check("bp_a_in_ready_after", {31'b0, a_in_ready}, 32'd1);

        // Reset mid-packet drops held and buffered flits.
        a_sel_ready = 1'b0;
        send_a(9'h130, 3'd0);
        send_a(9'h0A0, 3'd1);
        rst = 1'b1;
        @(negedge CLK);
        check("midrst_a_in_ready", {31'b0, a_in_ready}, 32'd0);
        qa.delete();
        rst = 1'b0;
        a_sel_ready = 1'b1;
        @(negedge CLK);
        check("midrst_a_sel_valid", {31'b0, a_sel_valid}, 32'd0);
        check("midrst_a_in_ready_after", {31'b0, a_in_ready}, 32'd1);
        repeat (6) @(negedge CLK);
        check("midrst_a_quiet_sel", {31'b0, a_sel_valid}, 32'd0);
        check("midrst_a_quiet_out", {30'b0, a_out_valid}, 32'd0);

        // Traffic still flows after the mid-packet reset.
        send_a(9'h1F0, 3'd1);
        drain_a();

`ifdef NOC_ROUTE_CNT_EN
        // Port 1 has seen exactly one transfer since the mid-packet reset.
        check("cnt_a_port1", {16'b0, a_route_cnt[31:16]}, 32'd1);
        force dut_a.g_cnt[0].cnt_q = 16'hFFFE;
        @(negedge CLK);
        release dut_a.g_cnt[0].cnt_q;
        @(negedge CLK);
        send_a(9'h130, 3'd0);
        send_a(9'h110, 3'd0);
        send_a(9'h100, 3'd0);
        drain_a();
        check("cnt_a_port0_sat", {16'b0, a_route_cnt[15:0]}, 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
